alu_arbiter: RTL and testbench

ALU_ARBITER -- requirements
Module: alu_arbiter

---
 rtl/alu_arbiter_if.sv | 65 ++++++
 rtl/alu_arbiter.sv | 188 ++++++++++++++++++
 tb/tb_alu_arbiter.sv | 294 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/alu_arbiter_if.sv
//-----------------------------------------------------------------------------
// alu_arbiter_if
// Bundles every handshake and bus signal of the two-requester ALU arbiter:
//   req0_* / req1_*   : command channels (valid/ready, opcode, operands a/b)
//   resp0_* / resp1_* : response channels (valid/ready, result, error)
//   alu_*             : command/result path to the shared ALU
//   busy              : arbiter is not idle
// modport slave  : the arbiter side
// modport master : the requesters + ALU environment side
//-----------------------------------------------------------------------------
`timescale 1ns/1ps
interface alu_arbiter_if;
  logic        req0_valid;
  logic        req0_ready;
  logic [2:0]  req0_opcode;
  logic [7:0]  req0_a;
  logic [7:0]  req0_b;
  logic        req1_valid;
  logic        req1_ready;
  logic [2:0]  req1_opcode;
  logic [7:0]  req1_a;
  logic [7:0]  req1_b;

  logic        resp0_valid;
  logic        resp0_ready;
  logic [15:0] resp0_result;
  logic        resp0_error;
  logic        resp1_valid;
  logic        resp1_ready;
  logic [15:0] resp1_result;
  logic        resp1_error;

  logic        alu_start;
  logic [2:0]  alu_opcode;
  logic [7:0]  alu_a;
  logic [7:0]  alu_b;
  logic [15:0] alu_result;
  logic        alu_done;

  logic        busy;

  modport slave (
    input  req0_valid, req0_opcode, req0_a, req0_b,
    input  req1_valid, req1_opcode, req1_a, req1_b,
    output req0_ready, req1_ready,
    output resp0_valid, resp0_result, resp0_error,
    output resp1_valid, resp1_result, resp1_error,
    input  resp0_ready, resp1_ready,
    output alu_start, alu_opcode, alu_a, alu_b,
    input  alu_result, alu_done,
    output busy
  );

  modport master (
    output req0_valid, req0_opcode, req0_a, req0_b,
    output req1_valid, req1_opcode, req1_a, req1_b,
    input  req0_ready, req1_ready,
    input  resp0_valid, resp0_result, resp0_error,
    input  resp1_valid, resp1_result, resp1_error,
    output resp0_ready, resp1_ready,
    input  alu_start, alu_opcode, alu_a, alu_b,
    output alu_result, alu_done,
    input  busy
  );
endinterface

// File: rtl/alu_arbiter.sv
//-----------------------------------------------------------------------------
// alu_arbiter
// Shares one ALU between two requesters. One command is in flight at a time;
// requesters are granted round-robin while idle, the command is issued to the
// ALU with a one-cycle start pulse, the result (or a timeout error) is
// returned on the owning requester's response channel and held until taken.
//
// Ports
//   clk    : rising-edge clock
//   rst_n  : asynchronous active-low reset
//   bus    : alu_arbiter_if.slave (request, response, ALU and busy signals)
// Parameter
//   TIMEOUT : WAIT cycles allowed before the operation is aborted with error
//-----------------------------------------------------------------------------
`timescale 1ns/1ps
module alu_arbiter #(
  parameter int TIMEOUT = 32
) (
  input  logic         clk,
  input  logic         rst_n,
  alu_arbiter_if.slave bus
);

  localparam int CNT_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } state_e;

  // Control state (reset)
  state_e           state_q, state_d;
  logic             prio_q, prio_d;    // requester holding priority
  logic             id_q, id_d;        // owner of the in-flight command
  logic [CNT_W-1:0] cnt_q, cnt_d;      // WAIT cycle counter

  // Command / response payload (no reset; every use is gated by state)
  logic [2:0]       op_q, op_d;
  logic [7:0]       a_q, a_d;
  logic [7:0]       b_q, b_d;
  logic [15:0]      res_q, res_d;
  logic             err_q, err_d;

  // Arbitration
  logic             gnt_vld;
  logic             gnt_id;
  logic [2:0]       sel_op;
  logic [7:0]       sel_a;
  logic [7:0]       sel_b;
  logic             own_ready;

  // Grant is purely combinational. It is masked by rst_n so that the ready
  // outputs stay low while reset is held even though the state reads IDLE.
  always_comb begin
    gnt_vld = 1'b0;
    gnt_id  = 1'b0;
    if (rst_n && (state_q == IDLE)) begin
      if (bus.req0_valid && bus.req1_valid) begin
        gnt_vld = 1'b1;
        gnt_id  = prio_q;
      end else if (bus.req0_valid) begin
        gnt_vld = 1'b1;
        gnt_id  = 1'b0;
      end else if (bus.req1_valid) begin
        gnt_vld = 1'b1;
        gnt_id  = 1'b1;
      end
    end
  end

  assign sel_op    = gnt_id ? bus.req1_opcode : bus.req0_opcode;
  assign sel_a     = gnt_id ? bus.req1_a      : bus.req0_a;
  assign sel_b     = gnt_id ? bus.req1_b      : bus.req0_b;
  assign own_ready = id_q ? bus.resp1_ready : bus.resp0_ready;

  assign bus.req0_ready = gnt_vld && !gnt_id;
  assign bus.req1_ready = gnt_vld &&  gnt_id;

  // Next-state logic
  always_comb begin
    state_d = state_q;
    prio_d  = prio_q;
    id_d    = id_q;
    cnt_d   = '0;
    op_d    = op_q;
    a_d     = a_q;
    b_d     = b_q;
    res_d   = res_q;
    err_d   = err_q;

    unique case (state_q)
      IDLE: begin
        if (gnt_vld) begin
          id_d   = gnt_id;
          prio_d = ~gnt_id;
          op_d   = sel_op;
          a_d    = sel_a;
          b_d    = sel_b;
          // Opcode 000 is a no-op: answer immediately without the ALU.
          if (sel_op == 3'b000) begin
            res_d   = 16'h0000;
            err_d   = 1'b0;
            state_d = RESP;
          end else begin
            state_d = ISSUE;
          end
        end
      end

      ISSUE: begin
        state_d = WAIT;
      end

      WAIT: begin
        // alu_done is checked first so it wins over a coinciding timeout.
        if (bus.alu_done) begin
          res_d   = bus.alu_result;
          err_d   = 1'b0;
          state_d = RESP;
        end else if (cnt_q == CNT_LAST) begin
          res_d   = 16'h0000;
          err_d   = 1'b1;
          state_d = RESP;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      RESP: begin
        if (own_ready) begin
          state_d = IDLE;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      prio_q  <= 1'b0;
      id_q    <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      prio_q  <= prio_d;
      id_q    <= id_d;
      cnt_q   <= cnt_d;
    end
  end

  always_ff @(posedge clk) begin
    op_q  <= op_d;
    a_q   <= a_d;
    b_q   <= b_d;
    res_q <= res_d;
    err_q <= err_d;
  end

  // Outputs. The ALU bus carries the command only while ISSUE/WAIT so it is
  // stable for the whole operation and zero otherwise.
  logic alu_active;
  logic in_resp;

  assign alu_active = (state_q == ISSUE) || (state_q == WAIT);
  assign in_resp    = (state_q == RESP);

  assign bus.alu_start  = (state_q == ISSUE);
  assign bus.alu_opcode = alu_active ? op_q : 3'b000;
  assign bus.alu_a      = alu_active ? a_q  : 8'h00;
  assign bus.alu_b      = alu_active ? b_q  : 8'h00;

  assign bus.resp0_valid  = in_resp && !id_q;
  assign bus.resp1_valid  = in_resp &&  id_q;
  assign bus.resp0_result = (in_resp && !id_q) ? res_q : 16'h0000;
  assign bus.resp1_result = (in_resp &&  id_q) ? res_q : 16'h0000;
  assign bus.resp0_error  = in_resp && !id_q && err_q;
  assign bus.resp1_error  = in_resp &&  id_q && err_q;

  assign bus.busy = (state_q != IDLE);

endmodule

// File: tb/tb_alu_arbiter.sv
`timescale 1ns/1ps
module tb_alu_arbiter;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  alu_arbiter_if bus_if();

  alu_arbiter #(.TIMEOUT(32)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus_if)
  );

  int   n_chk  = 0;
  int   n_fail = 0;
  int   alu_lat = 1;        // cycles from start to done; 0 = never done
  logic force_done = 1'b0;  // extra done pulse outside of any operation

  typedef struct {
    int          id;
    logic [2:0]  op;
    logic [7:0]  a;
    logic [7:0]  b;
    int          lat;
    logic [15:0] res;
    logic        err;
    int          cyc;       // edges from acceptance to resp_valid
  } vec_t;

  vec_t tbl[6];

  function automatic logic [15:0] alu_fn(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b);
    casez (op)
      3'b001:  return {8'h00, a} + {8'h00, b};
      3'b010:  return {8'h00, a & b};
      3'b011:  return {8'h00, a ^ b};
      3'b1??:  return a * b;
      default: return 16'h0000;
    endcase
  endfunction

  // ALU model: done is registered alu_lat cycles after the start cycle.
  initial begin : alu_model
    int rem;
    logic [15:0] res;
    rem = 0;
    res = 16'h0000;
    bus_if.alu_done   = 1'b0;
    bus_if.alu_result = 16'h0000;
    forever begin
      @(posedge clk);
      #1;
      bus_if.alu_done   = force_done;
      bus_if.alu_result = 16'h0000;
      if (!rst_n) begin
        rem = 0;
      end else if (rem > 0) begin
        rem--;
        if (rem == 0) begin
          bus_if.alu_done   = 1'b1;
          bus_if.alu_result = res;
        end
      end
      if (rst_n && bus_if.alu_start) begin
        rem = alu_lat;
        res = alu_fn(bus_if.alu_opcode, bus_if.alu_a, bus_if.alu_b);
      end
    end
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int id, input logic v, input logic [2:0] op, input logic [7:0] a, input logic [7:0] b);
    if (id == 0) begin
      bus_if.req0_valid = v; bus_if.req0_opcode = op; bus_if.req0_a = a; bus_if.req0_b = b;
    end else begin
      bus_if.req1_valid = v; bus_if.req1_opcode = op; bus_if.req1_a = a; bus_if.req1_b = b;
    end
  endtask

  task automatic set_rr(input int id, input logic v);
    if (id == 0) bus_if.resp0_ready = v;
    else         bus_if.resp1_ready = v;
  endtask

  function automatic logic rdy(input int id);
    return (id == 0) ? bus_if.req0_ready : bus_if.req1_ready;
  endfunction

  function automatic logic rsp_v(input int id);
    return (id == 0) ? bus_if.resp0_valid : bus_if.resp1_valid;
  endfunction

  function automatic logic [15:0] rsp_r(input int id);
    return (id == 0) ? bus_if.resp0_result : bus_if.resp1_result;
  endfunction

  function automatic logic rsp_e(input int id);
    return (id == 0) ? bus_if.resp0_error : bus_if.resp1_error;
  endfunction

  function automatic logic [63:0] all_outs();
    return {5'd0, bus_if.busy, bus_if.req0_ready, bus_if.req1_ready,
            bus_if.resp0_valid, bus_if.resp1_valid, bus_if.resp0_error, bus_if.resp1_error,
            bus_if.alu_start, bus_if.alu_opcode, bus_if.alu_a, bus_if.alu_b,
            bus_if.resp0_result, bus_if.resp1_result};
  endfunction

  // Issue one command (called one time unit after an edge), follow it to the
  // response, check it, and consume it.
  task automatic do_cmd(input vec_t v, input string nm);
    int n, starts;
    bit got, stable, othr;
    alu_lat = v.lat;
    set_req(v.id, 1'b1, v.op, v.a, v.b);
    #1;
    chk({nm, " ready"}, 64'(rdy(v.id)), 64'd1);
    n = 0; starts = 0; got = 0; stable = 1; othr = 0;
    while (!got && n < 60) begin
      tick();
      n++;
      if (n == 1) set_req(v.id, 1'b0, 3'b000, 8'h00, 8'h00);
      #1;
      if (bus_if.alu_start) starts++;
      got = rsp_v(v.id);
      if (!got && (bus_if.alu_opcode !== v.op || bus_if.alu_a !== v.a || bus_if.alu_b !== v.b))
        stable = 0;
      if (rsp_v(1 - v.id)) othr = 1;
    end
    chk({nm, " latency"}, 64'(n), 64'(v.cyc));
    chk({nm, " starts"}, 64'(starts), (v.op == 3'b000) ? 64'd0 : 64'd1);
    chk({nm, " operands stable"}, 64'(stable), 64'd1);
    chk({nm, " other resp"}, 64'(othr), 64'd0);
    chk({nm, " result"}, 64'(rsp_r(v.id)), 64'(v.res));
    chk({nm, " error"}, 64'(rsp_e(v.id)), 64'(v.err));
    set_rr(v.id, 1'b1);
    tick();
    set_rr(v.id, 1'b0);
    #1;
    chk({nm, " idle after"}, {62'd0, bus_if.busy, rsp_v(v.id)}, 64'd0);
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin : main
    bit bad, both;
    int w, g, cnt0, cnt1;
    int exp_g[4];
    vec_t v;

    //            id  op      a      b      lat res       err cyc
    tbl[0] = '{0, 3'b001, 8'hFF, 8'h01, 1,  16'h0100, 1'b0, 3};
    tbl[1] = '{1, 3'b100, 8'd12, 8'd13, 9,  16'd156,  1'b0, 11};
    tbl[2] = '{0, 3'b010, 8'hF0, 8'h3C, 0,  16'h0000, 1'b1, 34};
    tbl[3] = '{0, 3'b010, 8'hF0, 8'h3C, 32, 16'h0030, 1'b0, 34};
    tbl[4] = '{1, 3'b011, 8'hAA, 8'h55, 3,  16'h00FF, 1'b0, 5};
    tbl[5] = '{0, 3'b000, 8'h12, 8'h34, 1,  16'h0000, 1'b0, 1};

    rst_n = 1'b0;
    set_req(0, 1'b0, 3'b000, 8'h00, 8'h00);
    set_req(1, 1'b0, 3'b000, 8'h00, 8'h00);
    bus_if.resp0_ready = 1'b0;
    bus_if.resp1_ready = 1'b0;

    // Reset state, with a request pending that must not be granted.
    set_req(0, 1'b1, 3'b001, 8'hFF, 8'h01);
    tick(); tick(); tick();
    chk("reset outputs", all_outs(), 64'd0);
    rst_n = 1'b1;

    // Table vectors; the first is granted on the first edge after release.
    for (int i = 0; i < 6; i++) do_cmd(tbl[i], $sformatf("vec%0d", i));

    // alu_done outside WAIT is ignored.
    force_done = 1'b1;
    tick(); tick();
    force_done = 1'b0;
    #1;
    chk("stray done", {61'd0, bus_if.busy, bus_if.resp0_valid, bus_if.resp1_valid}, 64'd0);
    tick();

    // No-op held in RESP for 5 cycles while req1 waits.
    set_req(0, 1'b1, 3'b000, 8'h05, 8'h06);
    #1;
    chk("hold ready", 64'(bus_if.req0_ready), 64'd1);
    tick();
    set_req(0, 1'b0, 3'b000, 8'h00, 8'h00);
    set_req(1, 1'b1, 3'b001, 8'h10, 8'h20);
    alu_lat = 1;
    #1;
    bad = 0;
    for (int i = 0; i < 5; i++) begin
      if (!bus_if.resp0_valid || bus_if.resp0_result !== 16'h0000 || bus_if.resp0_error || bus_if.req1_ready)
        bad = 1;
      tick();
      #1;
    end
    chk("hold stable", 64'(bad), 64'd0);
    set_rr(0, 1'b1);
    #0;
    chk("no grant on resp exit", 64'(bus_if.req1_ready), 64'd0);
    tick();
    set_rr(0, 1'b0);
    #1;
    chk("grant after resp", {62'd0, bus_if.busy, bus_if.req1_ready}, 64'd1);
    tick();
    set_req(1, 1'b0, 3'b000, 8'h00, 8'h00);
    w = 0;
    while (!bus_if.resp1_valid && w < 20) begin tick(); #1; w++; end
    chk("req1 after hold", 64'(bus_if.resp1_result), 64'h0030);
    set_rr(1, 1'b1);
    tick();
    set_rr(1, 1'b0);
    #1;

    // Reset during WAIT.
    alu_lat = 0;
    set_req(0, 1'b1, 3'b010, 8'h11, 8'h22);
    #1;
    chk("rst ready", 64'(bus_if.req0_ready), 64'd1);
    tick();
    set_req(0, 1'b0, 3'b000, 8'h00, 8'h00);
    tick(); tick();
    #1;
    chk("rst pre", {53'd0, bus_if.busy, bus_if.alu_opcode, bus_if.alu_a}, {53'd0, 1'b1, 3'b010, 8'h11});
    rst_n = 1'b0;
    #1;
    chk("rst async outputs", all_outs(), 64'd0);
    tick(); tick();
    rst_n = 1'b1;
    bad = 0;
    for (int i = 0; i < 40; i++) begin
      tick();
      #1;
      if (bus_if.busy || bus_if.resp0_valid || bus_if.resp1_valid) bad = 1;
    end
    chk("no resp after reset", 64'(bad), 64'd0);
    v = '{1, 3'b001, 8'h02, 8'h03, 1, 16'h0005, 1'b0, 3};
    do_cmd(v, "post-reset req1");

    // Round-robin with both requesters valid for 4 commands.
    exp_g[0] = 0; exp_g[1] = 1; exp_g[2] = 0; exp_g[3] = 1;
    cnt0 = 0; cnt1 = 0; both = 0;
    alu_lat = 1;
    set_req(0, 1'b1, 3'b010, 8'hF0, 8'h3C);
    set_req(1, 1'b1, 3'b011, 8'hAA, 8'h55);
    #1;
    for (int k = 0; k < 4; k++) begin
      w = 0;
      while (!(bus_if.req0_ready || bus_if.req1_ready) && w < 20) begin tick(); #1; w++; end
      if (bus_if.req0_ready && bus_if.req1_ready) both = 1;
      g = bus_if.req1_ready ? 1 : 0;
      chk($sformatf("rr grant%0d", k), 64'(g), 64'(exp_g[k]));
      tick();
      if (g == 0) begin cnt0++; if (cnt0 == 2) set_req(0, 1'b0, 3'b000, 8'h00, 8'h00); end
      else        begin cnt1++; if (cnt1 == 2) set_req(1, 1'b0, 3'b000, 8'h00, 8'h00); end
      #1;
      w = 0;
      while (!rsp_v(exp_g[k]) && w < 20) begin
        if (bus_if.req0_ready && bus_if.req1_ready) both = 1;
        tick(); #1; w++;
      end
      chk($sformatf("rr result%0d", k),
          {46'd0, rsp_v(1 - exp_g[k]), rsp_v(exp_g[k]), rsp_r(exp_g[k])},
          {46'd0, 1'b0, 1'b1, (exp_g[k] == 0) ? 16'h0030 : 16'h00FF});
      set_rr(exp_g[k], 1'b1);
      tick();
      set_rr(exp_g[k], 1'b0);
      #1;
    end
    chk("rr never both ready", 64'(both), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
